// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the iterative shifter.
package shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_stage_var.sv
// One combinational shift stage: moves i_data by 2**i_k positions for the given op.
// Rotate support is compiled in only when SHIFT_ROTATE_EN is defined.
module shift_stage_var
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STG_W   = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [STG_W-1:0] i_k,
  input  shift_op_e        i_op,
  output logic [WIDTH-1:0] o_data
);

  logic        [SHAMT_W-1:0] w_amt;
  logic signed [WIDTH-1:0]   w_sdata;
  logic        [WIDTH-1:0]   w_sll;
  logic        [WIDTH-1:0]   w_srl;
  logic        [WIDTH-1:0]   w_sra;

  assign w_amt   = SHAMT_W'(1) << i_k;
  assign w_sdata = i_data;
  assign w_sll   = i_data << w_amt;
  assign w_srl   = i_data >> w_amt;
  assign w_sra   = w_sdata >>> w_amt;

`ifdef SHIFT_ROTATE_EN
  logic [SHAMT_W:0]   w_ramt;
  logic [WIDTH-1:0]   w_rol;
  // Stage amounts are never zero, so the complementary right shift stays below WIDTH.
  assign w_ramt = (SHAMT_W+1)'(WIDTH) - {1'b0, w_amt};
  assign w_rol  = w_sll | (i_data >> w_ramt);
`endif

  always_comb begin
    o_data = w_sll;
    case (i_op)
      OP_SRA:  o_data = w_sra;
      OP_SRL:  o_data = w_srl;
`ifdef SHIFT_ROTATE_EN
      OP_ROL:  o_data = w_rol;
`endif
      default: o_data = w_sll;
    endcase
  end

endmodule

// File: rtl/shift_iter_unit.sv
// Iterative 32-bit shifter: one power-of-two stage per cycle, MSB stage first,
// fixed SHAMT_W-cycle latency with valid/ready on both sides. Optional macro: SHIFT_ROTATE_EN.
module shift_iter_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int STG_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  shift_state_e       r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_shamt;
  shift_op_e          r_op;
  logic [STG_W-1:0]   r_stage;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_busy;

  logic [WIDTH-1:0]   w_stage_data;
  logic [WIDTH-1:0]   w_acc_next;

  shift_stage_var #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .STG_W   (STG_W)
  ) u_stage (
    .i_data (r_acc),
    .i_k    (r_stage),
    .i_op   (r_op),
    .o_data (w_stage_data)
  );

  assign w_acc_next = r_shamt[r_stage] ? w_stage_data : r_acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_shamt     <= '0;
      r_op        <= OP_SLL;
      r_stage     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_acc      <= in_data;
            r_shamt    <= in_shamt;
            r_op       <= shift_op_e'(in_op);
            r_stage    <= STG_W'(SHAMT_W - 1);
            r_state    <= ST_SHIFT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_acc <= w_acc_next;
          if (r_stage == '0) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_next;
          end else begin
            r_stage <= r_stage - STG_W'(1);
          end
        end
        ST_DONE: begin
          // Return to IDLE only; a new operand is taken no earlier than the following edge.
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Self-checking bench for shift_iter_unit: directed corner cases plus random ops vs a reference model.
module tb_shift_iter_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int errors;
  int checks;

  shift_iter_unit dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole shift applied at once from the op definition.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic [1:0] op);
    logic signed [31:0] sd;
    logic [63:0]        dd;
    sd = d;
    dd = {d, d} << sh;
    case (op)
      2'b01:   ref_shift = sd >>> sh;
      2'b10:   ref_shift = d >> sh;
`ifdef SHIFT_ROTATE_EN
      2'b11:   ref_shift = dd[63:32];
`endif
      default: ref_shift = d << sh;
    endcase
  endfunction

  // Drives one transaction; returns at the negedge where out_valid is first seen.
  task automatic do_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                       output logic [31:0] res, output int lat,
                       output bit proto_bad, output bit timeout);
    int w;
    res = '0; lat = 0; proto_bad = 0; timeout = 0; w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      timeout = 1;
      return;
    end
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_op = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (in_ready || !busy) proto_bad = 1;
    end while (!out_valid && lat < 20);
    if (!out_valid) timeout = 1;
    res = out_data;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] d [5] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1};
    logic [4:0]  s [5] = '{5'd4, 5'd31, 5'd31, 5'd0, 5'd31};
    logic [1:0]  o [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [31:0] e [5] = '{32'h10, 32'hFFFF_FFFF, 32'h1, 32'hDEAD_BEEF, 32'h8000_0000};
    logic [31:0] res;
    int lat;
    bit pb, to;
    for (int i = 0; i < 5; i++) begin
      do_op(d[i], s[i], o[i], res, lat, pb, to);
      checks++; if (to || res !== e[i]) begin errors++; $display("FAIL directed%0d_data got=%h want=%h timeout=%0d", i, res, e[i], to); end
      checks++; if (lat != 5) begin errors++; $display("FAIL directed%0d_latency got=%0d want=5", i, lat); end
      checks++; if (pb) begin errors++; $display("FAIL directed%0d_protocol in_ready/busy wrong while shifting", i); end
    end
    @(negedge clk);
  endtask

  task automatic test_rotate;
    logic [31:0] res, exp_v;
    int lat;
    bit pb, to;
`ifdef SHIFT_ROTATE_EN
    exp_v = 32'h0000_0003;
`else
    exp_v = 32'h0000_0002;
`endif
    do_op(32'h8000_0001, 5'd1, 2'b11, res, lat, pb, to);
    checks++; if (to || res !== exp_v) begin errors++; $display("FAIL rotate_data got=%h want=%h", res, exp_v); end
    checks++; if (lat != 5) begin errors++; $display("FAIL rotate_latency got=%0d want=5", lat); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] res, exp_v;
    int lat, bad;
    bit pb, to;
    out_ready = 1'b0;
    exp_v = ref_shift(32'h1234_5678, 5'd7, 2'b10);
    do_op(32'h1234_5678, 5'd7, 2'b10, res, lat, pb, to);
    checks++; if (to || res !== exp_v) begin errors++; $display("FAIL bp_data got=%h want=%h", res, exp_v); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom); in_op = 2'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== exp_v || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles want=0 (last data=%h)", bad, out_data); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_phantom_accept got busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    int seen;
    in_valid = 1'b1; in_data = 32'h0000_FFFF; in_shamt = 5'd3; in_op = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got=%b want=1", busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_async got valid=%b data=%h ready=%b busy=%b want 0/0/1/0",
                         out_valid, out_data, in_ready, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_stale got=%0d cycles with activity want=0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, res, exp_v;
    logic [4:0]  sh;
    logic [1:0]  op;
    int lat, hold, bad_data, bad_lat, bad_proto, bad_hold, bad_rel;
    bit pb, to;
    bad_data = 0; bad_lat = 0; bad_proto = 0; bad_hold = 0; bad_rel = 0;
    for (int n = 0; n < 100; n++) begin
      d = $urandom; sh = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
      exp_v = ref_shift(d, sh, op);
      out_ready = ($urandom_range(0, 3) != 0);
      do_op(d, sh, op, res, lat, pb, to);
      if (to || res !== exp_v) begin
        bad_data++;
        $display("FAIL b2b_data n=%0d d=%h sh=%0d op=%0d got=%h want=%h", n, d, sh, op, res, exp_v);
      end
      if (lat != 5) bad_lat++;
      if (pb) bad_proto++;
      if (!out_ready) begin
        hold = $urandom_range(1, 4);
        repeat (hold) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== exp_v) bad_hold++;
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad_rel++;
    end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL b2b_data_total got=%0d bad want=0", bad_data); end
    checks++; if (bad_lat != 0) begin errors++; $display("FAIL b2b_latency got=%0d bad want=0", bad_lat); end
    checks++; if (bad_proto != 0) begin errors++; $display("FAIL b2b_protocol got=%0d bad want=0", bad_proto); end
    checks++; if (bad_hold != 0) begin errors++; $display("FAIL b2b_hold got=%0d bad want=0", bad_hold); end
    checks++; if (bad_rel != 0) begin errors++; $display("FAIL b2b_release got=%0d bad want=0", bad_rel); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_rotate();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
